rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Registered, parametrised round-robin arbiter: the sequential successor to the combinational fixed-priority arbiter. It grants one of N requesters and holds the grant until the owner drops its request. Priority then rotates so the owner becomes lowest priority. It sits in front of shared resources such as buses, memory ports and FIFOs, where fairness and a stable, glitch-free grant are required.

## Interface
- N, 8, number of requesters; legal range 2..64
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation; used only when RR_ARB_MAX_HOLD_EN is defined; legal range ≥ 1
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- req  input  N  request vector; bit i = requester i wants the resource
- gnt  output  N  registered one-hot grant; all-zero when idle
- gnt_valid  output  1  high when gnt is non-zero
- gnt_id  output  $clog2(N)  binary index of the granted requester; 0 when gnt_valid=0

## Operation
- State: `state` ∈ {IDLE, BUSY}, `ptr` (clog2(N) bits) = highest-priority index, `owner` = current grantee.
- Search rule:
  - The winner is the first set bit of `req` scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Implementation uses a double-width masked priority encode or equivalent; the result must be exactly this.
- IDLE:
  - If req == 0, stay in IDLE with gnt = 0.
  - Otherwise go to BUSY with owner = winner(ptr, req), and set gnt, gnt_id and gnt_valid accordingly.
- BUSY, req[owner] = 1: hold gnt unchanged. `ptr` does not move.
- BUSY, req[owner] = 0 (release):
  - Set ptr = (owner+1) mod N.
  - Find the new winner using the new ptr over the current req.
  - If a winner exists, grant it next cycle (back-to-back, no idle bubble) and stay in BUSY.
  - Otherwise go to IDLE with gnt = 0.
- Wrap-around: owner N-1 releases → ptr = 0.
- Requests arriving or dropping on non-owner bits while BUSY never disturb gnt.
- gnt is always one-hot or zero. gnt_id == index of gnt whenever gnt_valid=1.
- After reset ptr = 0, so the first arbitration is identical to fixed priority (bit 0 highest).
- Reset mid-grant: gnt drops to 0 the cycle after rst is sampled high. ptr returns to 0.

## Timing
- Reset values: gnt = 0, gnt_valid = 0, gnt_id = 0, ptr = 0, state = IDLE, hold counter = 0.
- Request-to-grant latency is 1 cycle:
  - req sampled at edge k → gnt visible after edge k.
  - No combinational path from req to any output.
- Release-to-regrant latency is 1 cycle. The owner's req low at edge k means the new grant (or 0) follows edge k.
- rst high at an edge overrides all other activity at that edge.
- Requesters must hold req until granted. A dropped, ungranted request is simply not served; there is no error.

## Configuration
- Macro: RR_ARB_MAX_HOLD_EN.
- Defined:
  - A hold counter clears on every new grant and increments each BUSY cycle the owner keeps req high.
  - When the counter reaches MAX_HOLD-1 and (req & ~gnt) != 0, the grant is preempted: ptr = (owner+1) mod N and the new winner is granted next cycle.
  - If no other request is pending, the grant continues and the counter saturates at MAX_HOLD-1.
  - A grant therefore lasts at most MAX_HOLD cycles under contention.
- Not defined: no counter and no preemption. A grant lasts until the owner drops req. MAX_HOLD is ignored.

## Test plan
- Reset, then req=8'h00 for 3 cycles → gnt=0, gnt_valid=0, gnt_id=0 every cycle. Assert rst mid-grant → gnt=0 on the next cycle, and the next grant for req=8'hFF is gnt=8'h01.
- req=8'h09 → gnt=8'h01 one cycle later, held while req[0]=1. Drop bit 0 (req=8'h08) → gnt=8'h08, gnt_id=3 the next cycle with no zero cycle between.
- Rotation: req=8'hFF held constant with each owner dropping its bit for one cycle after its grant → grant order 0,1,2,…,7,0. Check wrap 7→0.
- Non-owner churn: owner=2, toggle req bits 0,5,7 randomly for 20 cycles with req[2]=1 → gnt stays 8'h04 throughout.
- Fairness: random req for 2000 cycles with release after 1–4 cycles → every cycle checks gnt one-hot/zero and gnt_id consistency. Any continuously pending requester waits at most N-1 grants.
- With RR_ARB_MAX_HOLD_EN, MAX_HOLD=4:
  - req=8'h03 held → gnt alternates 8'h01 for 4 cycles, then 8'h02 for 4 cycles.
  - req=8'h01 alone → gnt=8'h01 indefinitely.
  - Without the macro, req=8'h03 held → gnt stays 8'h01 indefinitely.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter.
//
// Grants one of N requesters and holds the grant until the owner drops its
// request. On release, priority rotates so that the old owner becomes lowest
// priority. A new winner is granted on the following cycle with no idle bubble.
// Every output comes from a register, so there is no combinational path from
// req to any output.
//
// Optional feature: define RR_ARB_MAX_HOLD_EN to enable a hold counter. When it
// is enabled, a grant is preempted after MAX_HOLD cycles if another requester
// is waiting.
//
// Parameters:
//   N         number of requesters (2..64)
//   MAX_HOLD  maximum consecutive grant cycles under contention (>= 1);
//             only used when RR_ARB_MAX_HOLD_EN is defined
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   req        request vector; bit i set = requester i wants the resource
//   gnt        registered one-hot grant; all-zero when idle
//   gnt_valid  high when gnt is non-zero
//   gnt_id     binary index of the granted requester; 0 when idle
module rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    if (N < 2 || N > 64 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_arbiter: N must be 2..64 and MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [W-1:0]   ptr;
    logic [W-1:0]   owner;

    logic [W-1:0]   rot_ptr;
    logic [W-1:0]   search_ptr;
    logic           owner_rel;
    logic           preempt;
    logic           win_found;
    logic [W-1:0]   win_idx;

`ifdef RR_ARB_MAX_HOLD_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
    logic [HW-1:0]  hold_cnt;
`endif

    // Return {found, index} for the first set bit of r, scanning
    // start, start+1, ..., N-1, 0, ..., start-1. The duplicated vector turns
    // the circular scan into a plain shift followed by a lowest-bit search.
    function automatic logic [W:0] search(input logic [W-1:0] start,
                                          input logic [N-1:0] r);
        logic [N-1:0] rot;
        logic [W-1:0] cur;
        logic [W-1:0] idx;
        logic         found;
        rot   = N'({r, r} >> start);
        cur   = start;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                idx   = cur;
            end
            rot = rot >> 1;
            cur = (cur == LAST) ? '0 : cur + 1'b1;
        end
        return {found, idx};
    endfunction

    always_comb begin
        rot_ptr   = (owner == LAST) ? '0 : owner + 1'b1;
        owner_rel = !req[owner];
`ifdef RR_ARB_MAX_HOLD_EN
        // Force rotation only when someone else is actually waiting;
        // a lone owner keeps the grant indefinitely.
        preempt   = (state == BUSY) && req[owner] && (hold_cnt == HOLD_TOP) &&
                    (|(req & ~gnt));
`else
        preempt   = 1'b0;
`endif
        // In BUSY the search only matters on release or preemption, and
        // then it starts just past the current owner.
        search_ptr = (state == BUSY) ? rot_ptr : ptr;
        {win_found, win_idx} = search(search_ptr, req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
`ifdef RR_ARB_MAX_HOLD_EN
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= BUSY;
                        owner     <= win_idx;
                        gnt       <= ONE << win_idx;
                        gnt_valid <= 1'b1;
                        gnt_id    <= win_idx;
`ifdef RR_ARB_MAX_HOLD_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (owner_rel || preempt) begin
                        ptr <= rot_ptr;
                        if (win_found) begin
                            // Back-to-back handover to the next winner.
                            owner     <= win_idx;
                            gnt       <= ONE << win_idx;
                            gnt_valid <= 1'b1;
                            gnt_id    <= win_idx;
`ifdef RR_ARB_MAX_HOLD_EN
                            hold_cnt  <= '0;
`endif
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                        end
                    end else begin
`ifdef RR_ARB_MAX_HOLD_EN
                        // Saturate so a lone owner does not wrap the counter.
                        if (hold_cnt != HOLD_TOP) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter (N=8, MAX_HOLD=4). The bench runs directed
// sequences followed by randomized traffic. Every cycle is compared against
// a behavioural round-robin model that keeps an abstract pointer/owner state.
// The bench also checks grant invariants and a fairness bound. It follows
// RR_ARB_MAX_HOLD_EN in the same way as the design does.
module tb_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam logic [N-1:0] ALL = '1;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic                 gnt_valid;
    logic [$clog2(N)-1:0] gnt_id;

    int checks;
    int failures;

    // model state
    int           m_busy;
    int           m_ptr;
    int           m_owner;
    int           m_hold;
    logic [N-1:0] exp_gnt;
    int           exp_id;
    int           exp_valid;

    // fairness tracking
    int           waits [N];
    int           max_wait;
    logic [N-1:0] prev_gnt;

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bit_of(input logic [N-1:0] r, input int i);
        logic [N-1:0] t;
        t = r >> i;
        return t[0] ? 1 : 0;
    endfunction

    // First requester at or after p in circular order, or -1 if none.
    function automatic int find(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (p + k) % N) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        int w;
        int pre;
        if (rs) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
        end else if (m_busy == 0) begin
            w = find(m_ptr, r);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_hold = 0;
            end
        end else begin
            pre = 0;
`ifdef RR_ARB_MAX_HOLD_EN
            if (bit_of(r, m_owner) != 0 && m_hold == MAX_HOLD - 1 &&
                (r & ~(N'(1) << m_owner)) != '0) pre = 1;
`endif
            if (bit_of(r, m_owner) == 0 || pre != 0) begin
                m_ptr = (m_owner + 1) % N;
                w = find(m_ptr, r);
                if (w >= 0) begin
                    m_owner = w; m_hold = 0;
                end else begin
                    m_busy = 0;
                end
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
        exp_gnt   = (m_busy != 0) ? (N'(1) << m_owner) : '0;
        exp_id    = (m_busy != 0) ? m_owner : 0;
        exp_valid = m_busy;
    endtask

    // One clock: drive, let the edge happen, update the model, then compare.
    task automatic cycle(input logic [N-1:0] r, input logic rs);
        logic new_grant;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("gnt_id", 64'(gnt_id), 64'(exp_id));
        chk("gnt_valid", 64'(gnt_valid), 64'(exp_valid));
        chk("onehot0", 64'($onehot0(gnt)), 64'(1));
        chk("id_consistent",
            64'(gnt_valid ? ((N'(1) << gnt_id) == gnt) : (gnt == '0 && gnt_id == '0)),
            64'(1));
        new_grant = gnt_valid && (gnt != prev_gnt);
        for (int i = 0; i < N; i++) begin
            if (rs || bit_of(r, i) == 0 || bit_of(gnt, i) != 0) begin
                waits[i] = 0;
            end else if (new_grant) begin
                waits[i]++;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
        end
        prev_gnt = gnt;
    endtask

    initial begin
        logic [N-1:0] cur_req;
        int           hold_left [N];

        checks = 0; failures = 0; max_wait = 0; prev_gnt = '0;
        m_busy = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
        exp_gnt = '0; exp_id = 0; exp_valid = 0;
        for (int i = 0; i < N; i++) begin
            waits[i] = 0;
            hold_left[i] = 0;
        end
        rst = 1'b1;
        req = '0;

        // Reset, then idle.
        cycle('0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle('0, 1'b0);
            chk("idle_gnt", 64'(gnt), 64'(0));
        end

        // Grant, hold, then back-to-back handover.
        cycle(8'h09, 1'b0);
        chk("first_gnt", 64'(gnt), 64'(8'h01));
        for (int c = 0; c < 3; c++) begin
            cycle(8'h09, 1'b0);
            chk("hold_gnt", 64'(gnt), 64'(8'h01));
        end
        cycle(8'h08, 1'b0);
        chk("handover_gnt", 64'(gnt), 64'(8'h08));
        chk("handover_id", 64'(gnt_id), 64'(3));
        cycle('0, 1'b0);

        // Reset mid-grant; fixed priority afterwards.
        cycle(ALL, 1'b0);
        cycle(ALL, 1'b1);
        chk("rst_mid_gnt", 64'(gnt), 64'(0));
        cycle(ALL, 1'b0);
        chk("post_rst_gnt", 64'(gnt), 64'(8'h01));

        // Rotation: each owner drops for one cycle; expect 1..7 then wrap to 0.
        for (int k = 1; k <= N; k++) begin
            cycle(ALL & ~(N'(1) << ((k - 1) % N)), 1'b0);
            chk("rotation_id", 64'(gnt_id), 64'(k % N));
        end

        // Non-owner churn while requester 2 owns the grant.
        cycle('0, 1'b1);
        cycle(8'h04, 1'b0);
        chk("churn_owner", 64'(gnt), 64'(8'h04));
        for (int c = 0; c < 20; c++) begin
            cycle(8'h04 | (N'($urandom) & 8'hA1), 1'b0);
`ifndef RR_ARB_MAX_HOLD_EN
            chk("churn_gnt", 64'(gnt), 64'(8'h04));
`endif
        end

        // Hold-limit behaviour with two steady requesters.
        cycle('0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            cycle(8'h03, 1'b0);
`ifdef RR_ARB_MAX_HOLD_EN
            chk("maxhold_alt", 64'(gnt), 64'(((c % 8) < 4) ? 8'h01 : 8'h02));
`else
            chk("no_preempt", 64'(gnt), 64'(8'h01));
`endif
        end
        cycle('0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cycle(8'h01, 1'b0);
            chk("lone_owner", 64'(gnt), 64'(8'h01));
        end

        // Randomized traffic: requests held until granted, released 1-4 cycles later.
        cycle('0, 1'b1);
        cur_req = '0;
        max_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bit_of(cur_req, i) != 0) begin
                    if (bit_of(exp_gnt, i) != 0) begin
                        if (hold_left[i] <= 1) cur_req = cur_req & ~(N'(1) << i);
                        else hold_left[i]--;
                    end
                end else if ($urandom_range(3) == 0) begin
                    cur_req = cur_req | (N'(1) << i);
                    hold_left[i] = int'($urandom_range(4, 1));
                end
            end
            cycle(cur_req, 1'b0);
        end
        chk("fairness_bound", 64'(max_wait <= N - 1), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
